// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath.
// The slave modport is the controller's view; master is the datapath/testbench view.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [2:0] ALUControl;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic       RegWrite;
  logic [3:0] state;

  modport slave (
    input  op, funct3, funct7b5, zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
           ALUSrcA, ALUSrcB, ImmSrc, RegWrite, state
  );

  modport master (
    output op, funct3, funct7b5, zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUControl,
           ALUSrcA, ALUSrcB, ImmSrc, RegWrite, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RISC-V datapath, with ALU decoder
// and immediate-format decode.
module multicycle_controller (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_controller_if.slave  ctl
);
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_e     state_q, state_d;
  logic       pc_update, branch;
  logic [1:0] alu_op;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:    state_d = DECODE;
      DECODE: begin
        case (ctl.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_R:         state_d = EXECUTER;
          OP_I:         state_d = EXECUTEI;
          OP_BEQ:       state_d = BEQ;
          OP_JAL:       state_d = JAL;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR:   state_d = (ctl.op == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD:  state_d = MEMWB;
      EXECUTER: state_d = ALUWB;
      EXECUTEI: state_d = ALUWB;
      JAL:      state_d = ALUWB;
      default:  state_d = FETCH;
    endcase
  end

  always_comb begin
    pc_update     = 1'b0;
    branch        = 1'b0;
    alu_op        = 2'b00;
    ctl.AdrSrc    = 1'b0;
    ctl.MemWrite  = 1'b0;
    ctl.IRWrite   = 1'b0;
    ctl.RegWrite  = 1'b0;
    ctl.ResultSrc = 2'b00;
    ctl.ALUSrcA   = 2'b00;
    ctl.ALUSrcB   = 2'b00;
    case (state_q)
      FETCH: begin
        ctl.IRWrite   = 1'b1;
        ctl.ALUSrcB   = 2'b10;
        ctl.ResultSrc = 2'b10;
        pc_update     = 1'b1;
      end
      DECODE: begin
        ctl.ALUSrcA = 2'b01;
        ctl.ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ctl.ALUSrcA = 2'b10;
        ctl.ALUSrcB = 2'b01;
      end
      MEMREAD:  ctl.AdrSrc = 1'b1;
      MEMWB: begin
        ctl.ResultSrc = 2'b01;
        ctl.RegWrite  = 1'b1;
      end
      MEMWRITE: begin
        ctl.AdrSrc   = 1'b1;
        ctl.MemWrite = 1'b1;
      end
      EXECUTER: begin
        ctl.ALUSrcA = 2'b10;
        alu_op      = 2'b10;
      end
      EXECUTEI: begin
        ctl.ALUSrcA = 2'b10;
        ctl.ALUSrcB = 2'b01;
        alu_op      = 2'b10;
      end
      ALUWB:    ctl.RegWrite = 1'b1;
      BEQ: begin
        ctl.ALUSrcA = 2'b10;
        alu_op      = 2'b01;
        branch      = 1'b1;
      end
      JAL: begin
        ctl.ALUSrcA = 2'b01;
        ctl.ALUSrcB = 2'b10;
        pc_update   = 1'b1;
      end
      default: ;
    endcase
    // The state flop already reads FETCH during reset; this also kills
    // FETCH's own enables so nothing is written while rst is held low.
    if (!rst) begin
      pc_update     = 1'b0;
      branch        = 1'b0;
      alu_op        = 2'b00;
      ctl.AdrSrc    = 1'b0;
      ctl.MemWrite  = 1'b0;
      ctl.IRWrite   = 1'b0;
      ctl.RegWrite  = 1'b0;
      ctl.ResultSrc = 2'b10;
      ctl.ALUSrcA   = 2'b00;
      ctl.ALUSrcB   = 2'b10;
    end
  end

  assign ctl.PCWrite = pc_update | (branch & ctl.zero);
  assign ctl.state   = state_q;

  always_comb begin
    ctl.ALUControl = 3'b000;
    case (alu_op)
      2'b01: ctl.ALUControl = 3'b001;
      2'b10: begin
        case (ctl.funct3)
          3'b000:  ctl.ALUControl = (ctl.op[5] & ctl.funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ctl.ALUControl = 3'b101;
          3'b110:  ctl.ALUControl = 3'b011;
          3'b111:  ctl.ALUControl = 3'b010;
          default: ctl.ALUControl = 3'b000;
        endcase
      end
      default: ctl.ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    ctl.ImmSrc = 2'b00;
    case (ctl.op)
      OP_SW:   ctl.ImmSrc = 2'b01;
      OP_BEQ:  ctl.ImmSrc = 2'b10;
      OP_JAL:  ctl.ImmSrc = 2'b11;
      default: ctl.ImmSrc = 2'b00;
    endcase
  end
endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: an instruction-level model predicts
// every output each cycle, and literal checks pin traces and decoded fields.
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic rst = 1'b0;
  multicycle_controller_if bus();

  multicycle_controller dut (.clk(clk), .rst(rst), .ctl(bus));

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: step number within the current instruction; the path through
  // the steps is chosen from the opcode when the instruction is fetched.
  int m_state = 0;
  int m_path[$];

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_state = 0;
      m_path.delete();
    end else if (m_state == 0) begin
      case (bus.op)
        7'b0000011: m_path = '{1, 2, 3, 4};
        7'b0100011: m_path = '{1, 2, 5};
        7'b0110011: m_path = '{1, 6, 8};
        7'b0010011: m_path = '{1, 7, 8};
        7'b1100011: m_path = '{1, 9};
        7'b1101111: m_path = '{1, 10, 8};
        default:    m_path = '{1};
      endcase
      m_state = m_path.pop_front();
    end else if (m_path.size() > 0) begin
      m_state = m_path.pop_front();
    end else begin
      m_state = 0;
    end
  end

  function automatic logic [2:0] alu_sem(input logic [6:0] o, input logic [2:0] f3, input logic f7);
    case (f3)
      3'b000:  return (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  // Packed as {state, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
  //            ALUControl, ALUSrcA, ALUSrcB, ImmSrc, RegWrite}.
  function automatic logic [19:0] expect_vec(input int st, input logic r);
    logic [3:0] s; logic pcw, adr, mw, irw, rw;
    logic [1:0] res, sa, sb, imm; logic [2:0] alu;
    s = 4'(st); pcw = 0; adr = 0; mw = 0; irw = 0; rw = 0;
    res = 2'b00; sa = 2'b00; sb = 2'b00; alu = 3'b000;
    case (bus.op)
      7'b0100011: imm = 2'b01;
      7'b1100011: imm = 2'b10;
      7'b1101111: imm = 2'b11;
      default:    imm = 2'b00;
    endcase
    if (!r) begin
      s = 4'd0; res = 2'b10; sb = 2'b10;
    end else begin
      case (st)
        0:  begin irw = 1; pcw = 1; sb = 2'b10; res = 2'b10; end
        1:  begin sa = 2'b01; sb = 2'b01; end
        2:  begin sa = 2'b10; sb = 2'b01; end
        3:  adr = 1;
        4:  begin res = 2'b01; rw = 1; end
        5:  begin adr = 1; mw = 1; end
        6:  begin sa = 2'b10; alu = alu_sem(bus.op, bus.funct3, bus.funct7b5); end
        7:  begin sa = 2'b10; sb = 2'b01; alu = alu_sem(bus.op, bus.funct3, bus.funct7b5); end
        8:  rw = 1;
        9:  begin sa = 2'b10; alu = 3'b001; pcw = bus.zero; end
        10: begin sa = 2'b01; sb = 2'b10; pcw = 1; end
        default: ;
      endcase
    end
    return {s, pcw, adr, mw, irw, res, alu, sa, sb, imm, rw};
  endfunction

  logic [31:0] trace;
  logic [2:0]  alu_seen;
  logic        pc_beq;

  initial forever begin
    @(negedge clk);
    chk("cycle", {12'd0, bus.state, bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite,
                  bus.ResultSrc, bus.ALUControl, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc,
                  bus.RegWrite},
        {12'd0, expect_vec(m_state, rst)});
    if (rst) begin
      trace = (trace << 4) | {28'd0, bus.state};
      if (bus.state inside {4'd6, 4'd7, 4'd9}) alu_seen = bus.ALUControl;
      if (bus.state == 4'd9) pc_beq = bus.PCWrite;
    end
  end

  task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                     input logic z, input int cycles);
    bus.op = o; bus.funct3 = f3; bus.funct7b5 = f7; bus.zero = z;
    trace = '0; alu_seen = 3'b111; pc_beq = 1'b0;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.op = 7'b0000011; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
    trace = '0; alu_seen = '0; pc_beq = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_enables", 32'({bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite}), 32'd0);
    chk("rst_alu", 32'(bus.ALUControl), 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("first_fetch", 32'({bus.IRWrite, bus.PCWrite}), 32'b11);

    run(7'b0000011, 3'b010, 1'b0, 1'b1, 5);
    chk("lw_trace", trace, 32'h01234);
    chk("lw_imm", 32'(bus.ImmSrc), 32'd0);
    run(7'b0100011, 3'b010, 1'b0, 1'b0, 4);
    chk("sw_trace", trace, 32'h0125);
    chk("sw_imm", 32'(bus.ImmSrc), 32'd1);
    run(7'b0110011, 3'b000, 1'b1, 1'b1, 4);
    chk("sub_alu", 32'(alu_seen), 32'b001);
    chk("r_trace", trace, 32'h0168);
    run(7'b0110011, 3'b000, 1'b0, 1'b0, 4);
    chk("add_alu", 32'(alu_seen), 32'b000);
    run(7'b0010011, 3'b000, 1'b1, 1'b1, 4);
    chk("addi_alu", 32'(alu_seen), 32'b000);
    run(7'b0110011, 3'b010, 1'b0, 1'b0, 4);
    chk("slt_alu", 32'(alu_seen), 32'b101);
    run(7'b0110011, 3'b111, 1'b0, 1'b0, 4);
    chk("and_alu", 32'(alu_seen), 32'b010);
    run(7'b0010011, 3'b110, 1'b0, 1'b0, 4);
    chk("ori_alu", 32'(alu_seen), 32'b011);
    run(7'b0110011, 3'b100, 1'b1, 1'b0, 4);
    chk("xor_alu", 32'(alu_seen), 32'b000);
    run(7'b1100011, 3'b000, 1'b0, 1'b1, 3);
    chk("beq_taken_pc", 32'(pc_beq), 32'd1);
    chk("beq_alu", 32'(alu_seen), 32'b001);
    chk("beq_trace", trace, 32'h019);
    chk("beq_imm", 32'(bus.ImmSrc), 32'd2);
    run(7'b1100011, 3'b000, 1'b0, 1'b0, 3);
    chk("beq_nt_pc", 32'(pc_beq), 32'd0);
    chk("beq_nt_state", 32'(bus.state), 32'd0);
    run(7'b1101111, 3'b000, 1'b0, 1'b1, 4);
    chk("jal_trace", trace, 32'h01A8);
    chk("jal_imm", 32'(bus.ImmSrc), 32'd3);
    run(7'b1111111, 3'b000, 1'b0, 1'b1, 2);
    chk("illegal_trace", trace, 32'h01);

    run(7'b0100011, 3'b010, 1'b0, 1'b0, 3);
    chk("memwrite_on", 32'({bus.state, bus.MemWrite}), 32'({4'd5, 1'b1}));
    rst = 1'b0;
    #1;
    chk("memwrite_abort", 32'({bus.state, bus.MemWrite}), 32'd0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    run(7'b0010011, 3'b111, 1'b0, 1'b0, 4);
    chk("andi_alu", 32'(alu_seen), 32'b010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
